spi_xfer_ctrl: RTL

Transfer sequencer for the SPI master datapath. Accepts one command per transfer (chip-select, bit length, TX word) over a valid/ready handshake. Enables and gates the SPI clock generator, consumes its rise/fall strobes to shift MOSI and sample MISO, and drives chip-selects. Returns the RX word over a valid/ready response channel.

---
 rtl/spi_xfer_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: takes one command per transfer, drives CS/MOSI from the
// clock generator strobes and returns the RX word. Optional macro: SPI_XFER_CS_DELAY_EN.
`timescale 1ns/1ps
module spi_xfer_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CS_NUM     = 4,
  localparam int unsigned LEN_W     = $clog2(DATA_WIDTH),
  localparam int unsigned CS_W      = $clog2(CS_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cfg_cpol_i,
  input  logic                  cfg_cpha_i,
  input  logic                  cfg_lsb_first_i,
`ifdef SPI_XFER_CS_DELAY_EN
  input  logic [7:0]            cfg_setup_i,
  input  logic [7:0]            cfg_hold_i,
`endif
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic [CS_W-1:0]       cmd_cs_i,
  input  logic                  cmd_keep_cs_i,
  input  logic [DATA_WIDTH-1:0] cmd_txdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rxdata_o,
  output logic                  clk_en_o,
  output logic                  cpol_o,
  input  logic                  spi_rise_i,
  input  logic                  spi_fall_i,
  output logic [CS_NUM-1:0]     spi_csn_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i,
  output logic                  busy_o
);

  localparam int unsigned BITS_W = LEN_W + 1;
  localparam int unsigned EDGE_W = LEN_W + 2;
  localparam int unsigned DLY_W  = 8;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, RESP} state_t;

  state_t                state_q, state_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic                  keep_q, keep_d;
  logic [BITS_W-1:0]     len_q, len_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [DLY_W-1:0]      cnt_q, cnt_d;
  logic [DLY_W-1:0]      hold_q, hold_d;

  logic                  cmd_ready_d, busy_d, rsp_valid_d, clk_en_d, cpol_d, mosi_d;
  logic [DATA_WIDTH-1:0] rsp_rxdata_d;
  logic [CS_NUM-1:0]     csn_d;

  logic                  lead, trail;
  logic [BITS_W-1:0]     len_v;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [LEN_W-1:0]      idx, pos;
  logic [EDGE_W-1:0]     last_edge;
  logic [DLY_W-1:0]      setup_val, hold_val;

`ifdef SPI_XFER_CS_DELAY_EN
  assign setup_val = cfg_setup_i;
  assign hold_val  = cfg_hold_i;
`else
  assign setup_val = '0;
  assign hold_val  = '0;
`endif

  // Reverse the low n bits so the shifter always emits from bit 0.
  function automatic logic [DATA_WIDTH-1:0] reverse_len(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [BITS_W-1:0] n);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i < 32'(n)) r[LEN_W'(i)] = w[LEN_W'(32'(n) - 32'd1 - i)];
    end
    return r;
  endfunction

  assign len_v     = (cmd_len_i == '0) ? BITS_W'(DATA_WIDTH) : BITS_W'(cmd_len_i);
  assign tx_word   = cfg_lsb_first_i ? cmd_txdata_i : reverse_len(cmd_txdata_i, len_v);
  assign lead      = cpol_o ? spi_fall_i : spi_rise_i;
  assign trail     = cpol_o ? spi_rise_i : spi_fall_i;
  assign idx       = LEN_W'(edge_q >> 1);
  assign pos       = lsb_q ? idx : LEN_W'(len_q - BITS_W'(1) - BITS_W'(idx));
  assign last_edge = EDGE_W'({len_q, 1'b0}) - EDGE_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cpha_d       = cpha_q;
    lsb_d        = lsb_q;
    keep_d       = keep_q;
    len_d        = len_q;
    shreg_d      = shreg_q;
    rx_d         = rx_q;
    edge_d       = edge_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    cmd_ready_d  = cmd_ready_o;
    busy_d       = busy_o;
    rsp_valid_d  = rsp_valid_o;
    rsp_rxdata_d = rsp_rxdata_o;
    clk_en_d     = clk_en_o;
    cpol_d       = cpol_o;
    mosi_d       = spi_mosi_o;
    csn_d        = spi_csn_o;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          state_d     = SETUP;
          cpol_d      = cfg_cpol_i;
          cpha_d      = cfg_cpha_i;
          lsb_d       = cfg_lsb_first_i;
          keep_d      = cmd_keep_cs_i;
          len_d       = len_v;
          shreg_d     = tx_word;
          mosi_d      = tx_word[0];
          rx_d        = '0;
          edge_d      = '0;
          cnt_d       = setup_val;
          hold_d      = hold_val;
          // Selecting the target line also releases a kept CS on a different index.
          csn_d       = ~(CS_NUM'(1) << cmd_cs_i);
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d  = XFER;
          clk_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      XFER: begin
        if (lead || trail) begin
          edge_d = edge_q + EDGE_W'(1);
          if (cpha_q ? trail : lead) rx_d[pos] = spi_miso_i;
          // With cpha=1 the first bit is already on MOSI before the first leading edge.
          if (cpha_q ? (lead && (edge_q != '0)) : trail) begin
            shreg_d = shreg_q >> 1;
            mosi_d  = shreg_d[0];
          end
          if (edge_q == last_edge) begin
            state_d  = HOLD;
            clk_en_d = 1'b0;
            cnt_d    = hold_q;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_rxdata_d = rx_q;
          if (!keep_q) csn_d = '1;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cpha_q       <= 1'b0;
      lsb_q        <= 1'b0;
      keep_q       <= 1'b0;
      len_q        <= '0;
      shreg_q      <= '0;
      rx_q         <= '0;
      edge_q       <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      cmd_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_rxdata_o <= '0;
      clk_en_o     <= 1'b0;
      cpol_o       <= 1'b0;
      spi_mosi_o   <= 1'b0;
      spi_csn_o    <= '1;
    end else begin
      state_q      <= state_d;
      cpha_q       <= cpha_d;
      lsb_q        <= lsb_d;
      keep_q       <= keep_d;
      len_q        <= len_d;
      shreg_q      <= shreg_d;
      rx_q         <= rx_d;
      edge_q       <= edge_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      cmd_ready_o  <= cmd_ready_d;
      busy_o       <= busy_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_rxdata_o <= rsp_rxdata_d;
      clk_en_o     <= clk_en_d;
      cpol_o       <= cpol_d;
      spi_mosi_o   <= mosi_d;
      spi_csn_o    <= csn_d;
    end
  end

endmodule
